// File: rtl/sdram_frame_reader_if.sv
// Signal bundle between the frame reader, the SDRAM read-port FIFO and the pixel sink.
// Pixel handshake: a beat transfers on a clock edge where PIX_VALID & PIX_READY are both high;
// once PIX_VALID is high, PIX_DATA and the SOF/EOL/EOF markers hold until that transfer.
interface sdram_frame_reader_if #(
  parameter int DSIZE = 16
);
  logic             FRAME_START;
  logic [DSIZE-1:0] RD_DATA;
  logic             RD_EMPTY;
  logic [15:0]      RD_USE;
  logic             RD;
  logic             RD_LOAD;
  logic [DSIZE-1:0] PIX_DATA;
  logic             PIX_VALID;
  logic             PIX_READY;
  logic             PIX_SOF;
  logic             PIX_EOL;
  logic             PIX_EOF;
  logic             BUSY;
  logic             UNDERRUN;
  logic [2:0]       DBG_STATE;

  modport master (
    input  FRAME_START, RD_DATA, RD_EMPTY, RD_USE, PIX_READY,
    output RD, RD_LOAD, PIX_DATA, PIX_VALID, PIX_SOF, PIX_EOL, PIX_EOF,
           BUSY, UNDERRUN, DBG_STATE
  );

  modport slave (
    output FRAME_START, RD_DATA, RD_EMPTY, RD_USE, PIX_READY,
    input  RD, RD_LOAD, PIX_DATA, PIX_VALID, PIX_SOF, PIX_EOL, PIX_EOF,
           BUSY, UNDERRUN, DBG_STATE
  );
endinterface

// File: rtl/sdram_frame_reader.sv
// Drains one SDRAM controller read FIFO and presents a frame as a valid/ready pixel stream
// with SOF/EOL/EOF markers; reloads the port at each frame start and flags underruns.
module sdram_frame_reader #(
  parameter int DSIZE       = 16,
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 240,
  parameter int LOAD_CYCLES = 4,
  parameter int PRIME_LEVEL = 64
) (
  input logic                  CLK,
  input logic                  RESET,
  sdram_frame_reader_if.master bus
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int NW = $clog2(H_ACTIVE * V_ACTIVE + 1);
  localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);
  localparam logic [NW-1:0] N_PIX   = NW'(H_ACTIVE * V_ACTIVE);
  localparam logic [LW-1:0] L_LAST  = LW'(LOAD_CYCLES - 1);
  localparam logic [15:0]   P_LEVEL = 16'(PRIME_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_PRIME  = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [LW-1:0]    r_load_cnt;
  logic [XW-1:0]    r_x;
  logic [YW-1:0]    r_y;
  logic [NW-1:0]    r_issued;
  logic [DSIZE-1:0] r_buf0;
  logic [DSIZE-1:0] r_buf1;
  logic [1:0]       r_count;
  logic             r_inflight;
  logic             r_underrun;

  logic       w_rd;
  logic       w_rd_load;
  logic       w_valid;
  logic       w_pop;
  logic       w_push;
  logic       w_eol;
  logic       w_eof;
  logic [2:0] w_occ;

  assign w_valid = (r_count != 2'd0);
  assign w_pop   = w_valid & bus.PIX_READY;
  assign w_push  = r_inflight & (r_state == S_STREAM);
  assign w_eol   = (r_x == X_LAST);
  assign w_eof   = w_eol & (r_y == Y_LAST);
  // Slots spoken for after this edge: the pop frees one, so a full-rate stream never bubbles.
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_rd      = 1'b0;
    w_rd_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.FRAME_START) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_rd_load = 1'b1;
        if (bus.FRAME_START)          w_next = S_LOAD;
        else if (r_load_cnt == L_LAST) w_next = S_PRIME;
      end
      S_PRIME: begin
        if (bus.FRAME_START) w_next = S_LOAD;
        else if ((bus.RD_USE >= P_LEVEL) && !bus.RD_EMPTY) w_next = S_STREAM;
      end
      S_STREAM: begin
        w_rd = !bus.FRAME_START && !bus.RD_EMPTY && (w_occ < 3'd2) && (r_issued < N_PIX);
        if (bus.FRAME_START)  w_next = S_LOAD;
        else if (w_pop && w_eof) w_next = S_DONE;
      end
      S_DONE: begin
        if (bus.FRAME_START) w_next = S_LOAD;
        else                 w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET || bus.FRAME_START || (r_state != S_LOAD)) r_load_cnt <= '0;
    else                                                 r_load_cnt <= r_load_cnt + LW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_inflight <= 1'b0;
      r_underrun <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_issued   <= '0;
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_count    <= 2'd0;
    end else begin
      r_inflight <= w_rd;
      if (bus.FRAME_START)
        r_underrun <= 1'b0;
      else if ((r_state == S_STREAM) && bus.PIX_READY && (r_count == 2'd0) &&
               !r_inflight && bus.RD_EMPTY)
        r_underrun <= 1'b1;

      // A restart or any non-streaming state discards buffered and in-flight words.
      if (bus.FRAME_START || (r_state != S_STREAM)) begin
        r_x      <= '0;
        r_y      <= '0;
        r_issued <= '0;
        r_buf0   <= '0;
        r_buf1   <= '0;
        r_count  <= 2'd0;
      end else begin
        if (w_rd) r_issued <= r_issued + NW'(1);
        if (w_pop) begin
          if (w_eol) begin
            r_x <= '0;
            r_y <= (r_y == Y_LAST) ? '0 : r_y + YW'(1);
          end else begin
            r_x <= r_x + XW'(1);
          end
        end
        case ({w_push, w_pop})
          2'b10: begin
            if (r_count == 2'd0) r_buf0 <= bus.RD_DATA;
            else                 r_buf1 <= bus.RD_DATA;
            r_count <= r_count + 2'd1;
          end
          2'b01: begin
            r_buf0  <= r_buf1;
            r_count <= r_count - 2'd1;
          end
          2'b11: begin
            if (r_count == 2'd1) begin
              r_buf0 <= bus.RD_DATA;
            end else begin
              r_buf0 <= r_buf1;
              r_buf1 <= bus.RD_DATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.RD        = w_rd;
  assign bus.RD_LOAD   = w_rd_load;
  assign bus.PIX_DATA  = r_buf0;
  assign bus.PIX_VALID = w_valid;
  assign bus.PIX_SOF   = w_valid && (r_x == '0) && (r_y == '0);
  assign bus.PIX_EOL   = w_valid && w_eol;
  assign bus.PIX_EOF   = w_valid && w_eof;
  assign bus.BUSY      = (r_state != S_IDLE);
  assign bus.UNDERRUN  = r_underrun;
  assign bus.DBG_STATE = r_state;

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Directed bench for sdram_frame_reader on a 4x2 frame with a behavioural read FIFO
// and a scoreboard of expected pixels (data plus SOF/EOL/EOF).
module tb_sdram_frame_reader;
  localparam int H = 4;
  localparam int V = 2;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_PRIME = 3'd2,
                         ST_STREAM = 3'd3, ST_DONE = 3'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tb_ready = 1'b1;
  int   rdy_mode = 0;

  sdram_frame_reader_if #(.DSIZE(16)) bus ();

  sdram_frame_reader #(
    .DSIZE(16), .H_ACTIVE(H), .V_ACTIVE(V), .LOAD_CYCLES(4), .PRIME_LEVEL(4)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [18:0] exp_q[$];
  logic [15:0] fifo_q[$];
  int fifo_n = 0;
  int fr_pos = 0;
  int tb_out = 0;
  int frame_acc = 0;
  logic hold_prev = 1'b0;

  assign bus.RD_EMPTY  = (fifo_n == 0);
  assign bus.RD_USE    = 16'(fifo_n);
  assign bus.PIX_READY = tb_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Non-show-ahead FIFO: a read sampled at an edge presents its word just after that edge.
  initial bus.RD_DATA = '0;
  always @(posedge clk) begin
    logic rd_s, ld_s;
    rd_s = bus.RD;
    ld_s = bus.RD_LOAD;
    #1;
    if (ld_s) fifo_q.delete();
    else if (rd_s && fifo_q.size() > 0) bus.RD_DATA = fifo_q.pop_front();
    fifo_n = fifo_q.size();
  end

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      1:       tb_ready = ~tb_ready;
      2:       tb_ready = 1'b0;
      default: tb_ready = 1'b1;
    endcase
  end

  // Scoreboard: every presented pixel must equal the oldest expected pixel.
  always @(negedge clk) begin
    logic acc;
    if (!rst) begin
      acc = bus.PIX_VALID && bus.PIX_READY;
      check("rd_on_empty", 32'(bus.RD && bus.RD_EMPTY), 32'd0);
      if (bus.RD) check("rd_capacity", 32'((tb_out + 1 - int'(acc)) <= 2), 32'd1);
      if (hold_prev) check("hold_valid", 32'(bus.PIX_VALID), 32'd1);
      if (bus.PIX_VALID) begin
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL stale_pixel: observed data %0h expected no pixel", bus.PIX_DATA);
        end
        if (exp_q.size() != 0) begin
          check("pixel", 32'({bus.PIX_SOF, bus.PIX_EOL, bus.PIX_EOF, bus.PIX_DATA}), 32'(exp_q[0]));
          if (acc) void'(exp_q.pop_front());
        end
      end
      hold_prev = bus.PIX_VALID && !bus.PIX_READY;
      tb_out    = tb_out + int'(bus.RD) - int'(acc);
      frame_acc = frame_acc + int'(acc);
    end
  end

  task automatic clear_model();
    exp_q.delete();
    fr_pos    = 0;
    tb_out    = 0;
    frame_acc = 0;
    hold_prev = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #2 bus.FRAME_START = 1'b1;
    @(posedge clk); #2 bus.FRAME_START = 1'b0;
    clear_model();
  endtask

  task automatic push_words(input int n, input logic [15:0] base);
    int x, y;
    logic sof, eol, eof;
    @(posedge clk); #2;
    for (int i = 0; i < n; i++) begin
      x   = fr_pos % H;
      y   = fr_pos / H;
      sof = (fr_pos == 0);
      eol = (x == H - 1);
      eof = eol && (y == V - 1);
      fifo_q.push_back(base + 16'(i));
      exp_q.push_back({sof, eol, eof, base + 16'(i)});
      fr_pos++;
    end
    fifo_n = fifo_q.size();
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, input string tag);
    int t = 0;
    while (bus.DBG_STATE !== s && t < limit) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(bus.DBG_STATE), 32'(s));
  endtask

  initial begin
    int ld, cyc, rd_c, v_c, t;
    bus.FRAME_START = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_state", 32'(bus.DBG_STATE), 32'(ST_IDLE));
    check("rst_rd", 32'(bus.RD), 32'd0);
    check("rst_rd_load", 32'(bus.RD_LOAD), 32'd0);
    check("rst_valid", 32'(bus.PIX_VALID), 32'd0);
    check("rst_markers", 32'({bus.PIX_SOF, bus.PIX_EOL, bus.PIX_EOF}), 32'd0);
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    check("rst_underrun", 32'(bus.UNDERRUN), 32'd0);
    check("rst_data", 32'(bus.PIX_DATA), 32'd0);

    // Frame 1: load pulse width, prime gating, first-pixel latency, full-rate burst.
    pulse_start();
    ld = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ld += int'(bus.RD_LOAD);
    end
    check("load_width", 32'(ld), 32'd4);
    check("prime_state", 32'(bus.DBG_STATE), 32'(ST_PRIME));
    push_words(3, 16'h0001);
    repeat (4) @(negedge clk);
    check("prime_hold_rd", 32'(bus.RD), 32'd0);
    check("prime_hold_state", 32'(bus.DBG_STATE), 32'(ST_PRIME));
    push_words(5, 16'h0004);
    cyc = 0; rd_c = -1; v_c = -1;
    while (v_c < 0 && cyc < 50) begin
      @(negedge clk);
      if (bus.RD && rd_c < 0) rd_c = cyc;
      if (bus.PIX_VALID) v_c = cyc;
      cyc++;
    end
    check("first_valid_latency", 32'(v_c - rd_c), 32'd2);
    for (int i = 0; i < 8; i++) begin
      check("burst_valid", 32'(bus.PIX_VALID), 32'd1);
      @(negedge clk);
    end
    check("done_state", 32'(bus.DBG_STATE), 32'(ST_DONE));
    check("done_busy", 32'(bus.BUSY), 32'd1);
    @(negedge clk);
    check("idle_state", 32'(bus.DBG_STATE), 32'(ST_IDLE));
    check("idle_busy", 32'(bus.BUSY), 32'd0);
    check("frame1_drained", 32'(exp_q.size()), 32'd0);

    // Frame 2: ready toggling every clock.
    pulse_start();
    wait_state(ST_PRIME, 20, "f2_prime");
    rdy_mode = 1;
    push_words(8, 16'h0011);
    wait_state(ST_DONE, 200, "f2_done");
    rdy_mode = 0;
    check("frame2_drained", 32'(exp_q.size()), 32'd0);

    // Frame 3: FIFO runs dry mid-line, then refills.
    pulse_start();
    wait_state(ST_PRIME, 20, "f3_prime");
    push_words(6, 16'h0021);
    t = 0;
    while (bus.UNDERRUN !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("underrun_set", 32'(bus.UNDERRUN), 32'd1);
    check("underrun_rd", 32'(bus.RD), 32'd0);
    check("underrun_state", 32'(bus.DBG_STATE), 32'(ST_STREAM));
    @(posedge clk); #1;
    check("underrun_accepted", 32'(frame_acc), 32'd6);
    repeat (3) @(negedge clk);
    check("underrun_sticky", 32'(bus.UNDERRUN), 32'd1);
    push_words(2, 16'h0027);
    wait_state(ST_DONE, 100, "f3_done");
    check("underrun_at_done", 32'(bus.UNDERRUN), 32'd1);
    check("frame3_drained", 32'(exp_q.size()), 32'd0);

    // Frame 4: restart at pixel 5; restart clears the underrun flag.
    pulse_start();
    @(negedge clk);
    check("underrun_cleared", 32'(bus.UNDERRUN), 32'd0);
    wait_state(ST_PRIME, 20, "f4_prime");
    push_words(8, 16'h0041);
    t = 0;
    while (frame_acc < 4 && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("abort_reach_px4", 32'(frame_acc), 32'd4);
    #2 bus.FRAME_START = 1'b1;
    @(posedge clk); #2 bus.FRAME_START = 1'b0;
    clear_model();
    @(negedge clk);
    check("abort_valid", 32'(bus.PIX_VALID), 32'd0);
    check("abort_rd_load", 32'(bus.RD_LOAD), 32'd1);
    check("abort_state", 32'(bus.DBG_STATE), 32'(ST_LOAD));
    ld = 1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      ld += int'(bus.RD_LOAD);
    end
    check("abort_load_width", 32'(ld), 32'd4);
    wait_state(ST_PRIME, 20, "f4_prime_again");
    push_words(8, 16'h0081);
    wait_state(ST_DONE, 100, "f4_done");
    check("frame4_drained", 32'(exp_q.size()), 32'd0);

    // Frame 5: synchronous reset while a read is being issued.
    pulse_start();
    wait_state(ST_PRIME, 20, "f5_prime");
    push_words(8, 16'h00A1);
    t = 0;
    while (bus.RD !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    check("rd_before_reset", 32'(bus.RD), 32'd1);
    @(posedge clk); #2 rst = 1'b0;
    clear_model();
    @(negedge clk);
    check("mid_rst_rd", 32'(bus.RD), 32'd0);
    check("mid_rst_valid", 32'(bus.PIX_VALID), 32'd0);
    check("mid_rst_busy", 32'(bus.BUSY), 32'd0);
    check("mid_rst_state", 32'(bus.DBG_STATE), 32'(ST_IDLE));
    check("mid_rst_data", 32'(bus.PIX_DATA), 32'd0);

    // Frame 6: counters restart from zero after the reset.
    pulse_start();
    wait_state(ST_PRIME, 20, "f6_prime");
    push_words(8, 16'h00C1);
    wait_state(ST_DONE, 100, "f6_done");
    check("frame6_drained", 32'(exp_q.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no end of test, expected finish before 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
